// File: rtl/cla_pkg.sv
// Shared constants and carry-lookahead helpers for the pipelined CLA adder.
// group_gp gives the 4-bit group terms; lookahead gives the group carries as sums of products.
package cla_pkg;
    localparam int GRP_W   = 4;
    localparam int MAX_GRP = 4;

    function automatic logic [1:0] group_gp(input logic [GRP_W-1:0] g, input logic [GRP_W-1:0] p);
        logic gg;
        logic pp;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pp = &p;
        return {gg, pp};
    endfunction

    // Each C(k+1) is built from the group terms directly, so no term waits on C(k).
    function automatic logic [MAX_GRP:0] lookahead(input logic [MAX_GRP-1:0] gg,
                                                   input logic [MAX_GRP-1:0] pp,
                                                   input logic               cin,
                                                   input int                 ngrp);
        logic [MAX_GRP:0] c;
        logic             term;
        logic             prop;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < MAX_GRP; k++) begin
            if (k < ngrp) begin
                term = 1'b0;
                prop = 1'b1;
                for (int j = k; j >= 0; j--) begin
                    term = term | (prop & gg[j]);
                    prop = prop & pp[j];
                end
                c[k+1] = term | (prop & cin);
            end
        end
        return c;
    endfunction
endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand and result handshake bundle for cla_pipe_adder.
// master drives operands and out_ready; slave (the adder) returns in_ready and the result.
interface cla_pipe_adder_if import cla_pkg::*; #(parameter int NGRP = 4);
    localparam int W = GRP_W * NGRP;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/cla_group4.sv
// Combinational 4-bit group: per-bit generate/propagate plus group GG/PP.
// No state, no handshake.
module cla_group4 import cla_pkg::*; (
    input  logic [GRP_W-1:0] a_i,
    input  logic [GRP_W-1:0] b_i,
    output logic [GRP_W-1:0] g_o,
    output logic [GRP_W-1:0] p_o,
    output logic             gg_o,
    output logic             pp_o
);
    assign g_o = a_i & b_i;
    assign p_o = a_i ^ b_i;
    assign {gg_o, pp_o} = group_gp(g_o, p_o);
endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage CLA adder: stage 1 registers g/p and group GG/PP, stage 2 registers sum/cout/ovf; 2-cycle latency, 1 beat/cycle.
// Stalls hold both stages; in_ready is combinational from out_ready, so integrators must not feed in_ready back into out_ready.
module cla_pipe_adder import cla_pkg::*; #(
    parameter int NGRP = 4
) (
    input  logic             clk,
    input  logic             rst,
    cla_pipe_adder_if.slave  bus
);
    localparam int W = GRP_W * NGRP;

    if (NGRP < 2 || NGRP > MAX_GRP) begin : g_bad_ngrp
        $error("cla_pipe_adder: NGRP must be in 2..4");
    end

    logic            v1_q, v1_d;
    logic            v2_q, v2_d;
    logic [W-1:0]    g1_q, g1_d;
    logic [W-1:0]    p1_q, p1_d;
    logic [NGRP-1:0] gg1_q, gg1_d;
    logic [NGRP-1:0] pp1_q, pp1_d;
    logic            cin1_q;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic            s2_en;
    logic            in_rdy;
    logic            in_fire;
    logic [MAX_GRP:0] grp_c;
    logic [W-1:0]    c_bit;
    logic            cc;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        cla_group4 u_grp (
            .a_i  (bus.a[GRP_W*k +: GRP_W]),
            .b_i  (bus.b[GRP_W*k +: GRP_W]),
            .g_o  (g1_d[GRP_W*k +: GRP_W]),
            .p_o  (p1_d[GRP_W*k +: GRP_W]),
            .gg_o (gg1_d[k]),
            .pp_o (pp1_d[k])
        );
    end

    assign s2_en   = !v2_q | bus.out_ready;
    assign in_rdy  = !v1_q | s2_en;
    assign in_fire = bus.in_valid & in_rdy;
    assign v1_d    = in_rdy ? in_fire : v1_q;
    assign v2_d    = s2_en ? v1_q : v2_q;

    assign grp_c = lookahead(MAX_GRP'(gg1_q), MAX_GRP'(pp1_q), cin1_q, NGRP);

    // Inside a group the carries ripple from that group's lookahead carry.
    always_comb begin
        c_bit = '0;
        cc    = 1'b0;
        for (int k = 0; k < NGRP; k++) begin
            cc = grp_c[k];
            for (int j = 0; j < GRP_W; j++) begin
                c_bit[GRP_W*k+j] = cc;
                cc = g1_q[GRP_W*k+j] | (p1_q[GRP_W*k+j] & cc);
            end
        end
    end

    assign sum_d  = p1_q ^ c_bit;
    assign cout_d = grp_c[NGRP];
    assign ovf_d  = grp_c[NGRP] ^ c_bit[W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            g1_q   <= '0;
            p1_q   <= '0;
            gg1_q  <= '0;
            pp1_q  <= '0;
            cin1_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            if (in_fire) begin
                g1_q   <= g1_d;
                p1_q   <= p1_d;
                gg1_q  <= gg1_d;
                pp1_q  <= pp1_d;
                cin1_q <= bus.cin;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            v2_q <= v2_d;
            if (s2_en) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = v2_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed vector table, latency/backpressure/reset sequences,
// and a randomized run scored against an arithmetic reference model.
module tb_cla_pipe_adder;
    import cla_pkg::*;

    localparam int NGRP = 4;
    localparam int W    = GRP_W * NGRP;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cla_pipe_adder_if #(.NGRP(NGRP)) bus ();
    cla_pipe_adder #(.NGRP(NGRP)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t exp_q[$];

    // Reference: plain integer addition; overflow when the signed sum leaves the W-bit range.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        res_t        r;
        logic [W:0]  full;
        longint      sa, sb, ss, lim;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        sa     = longint'($signed(a));
        sb     = longint'($signed(b));
        ss     = sa + sb + longint'(cin);
        lim    = longint'(1) << (W - 1);
        r.ovf  = (ss >= lim) || (ss < -lim);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted beat must leave exactly once, in order, with the model's result.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.a, bus.b, bus.cin));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("sb_sum",  32'(bus.sum), 32'(e.sum));
                    chk("sb_cout", 32'(bus.cout), 32'(e.cout));
                    chk("sb_ovf",  32'(bus.ovf), 32'(e.ovf));
                end
            end
        end
    end

    vec_t vt[6];
    res_t r;
    int   sent;
    int   cyc;
    logic fired;

    initial begin
        vt[0] = '{"carry_wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1] = '{"pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[2] = '{"neg_ovf_cin", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};
        vt[3] = '{"prop_chain",  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[4] = '{"no_carry",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[5] = '{"alt_prop",    16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};

        drive(1'b0, '0, '0, 1'b0);
        bus.out_ready = 1'b1;

        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum",       32'(bus.sum),       32'd0);
        chk("rst_cout",      32'(bus.cout),      32'd0);
        chk("rst_ovf",       32'(bus.ovf),       32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        next_cycle();
        rst = 1'b0;

        // Directed vectors, one beat at a time, with explicit latency checks.
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            drive(1'b1, vt[i].a, vt[i].b, vt[i].cin);
            @(negedge clk);
            chk({vt[i].name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
            next_cycle();
            bus.in_valid = 1'b0;
            @(negedge clk);
            chk({vt[i].name, "_early_valid"}, 32'(bus.out_valid), 32'd0);
            next_cycle();
            @(negedge clk);
            chk({vt[i].name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
            chk({vt[i].name, "_sum"},  32'(bus.sum),  32'(vt[i].sum));
            chk({vt[i].name, "_cout"}, 32'(bus.cout), 32'(vt[i].cout));
            chk({vt[i].name, "_ovf"},  32'(bus.ovf),  32'(vt[i].ovf));
        end
        repeat (3) next_cycle();

        // Back-to-back: 8 beats, results expected on 8 consecutive cycles from cycle 2.
        for (int t = 0; t < 12; t++) begin
            next_cycle();
            if (t < 8) drive(1'b1, W'(t), W'(3 * t), 1'(t & 1));
            else       drive(1'b0, '0, '0, 1'b0);
            @(negedge clk);
            if (t < 8) chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
            chk("b2b_out_valid", 32'(bus.out_valid), 32'((t >= 2) && (t <= 9)));
            if (t >= 2 && t <= 9) begin
                r = model(W'(t - 2), W'(3 * (t - 2)), 1'((t - 2) & 1));
                chk("b2b_sum", 32'(bus.sum), 32'(r.sum));
            end
        end

        // Backpressure: fill both stages, hold, then release.
        next_cycle();
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        chk("bp_rdy_beat1", 32'(bus.in_ready), 32'd1);
        next_cycle();
        drive(1'b1, 16'h3333, 16'h4444, 1'b1);
        @(negedge clk);
        chk("bp_rdy_beat2", 32'(bus.in_ready), 32'd1);
        next_cycle();
        drive(1'b1, 16'hF000, 16'h1000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(bus.in_ready),  32'd0);
            chk("bp_out_valid",    32'(bus.out_valid), 32'd1);
            chk("bp_sum_held",     32'(bus.sum),       32'h3333);
            next_cycle();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rdy_release", 32'(bus.in_ready), 32'd1);
        next_cycle();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_beat2_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_beat2_sum",   32'(bus.sum),       32'h7778);
        next_cycle();
        @(negedge clk);
        chk("bp_beat3_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_beat3_sum",   32'(bus.sum),       32'h0000);
        chk("bp_beat3_cout",  32'(bus.cout),      32'd1);
        next_cycle();
        @(negedge clk);
        chk("bp_drained", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset with both stages occupied.
        next_cycle();
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0F0F, 16'h00F1, 1'b0);
        next_cycle();
        drive(1'b1, 16'h1234, 16'h1111, 1'b1);
        next_cycle();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_pre_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("rstmid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rstmid_sum",       32'(bus.sum),       32'd0);
        chk("rstmid_cout",      32'(bus.cout),      32'd0);
        chk("rstmid_in_ready",  32'(bus.in_ready),  32'd1);
        next_cycle();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rstmid_no_stale", 32'(bus.out_valid), 32'd0);
            chk("rstmid_rdy_after", 32'(bus.in_ready), 32'd1);
        end

        // Random traffic with random backpressure; the scoreboard does the checking.
        sent  = 0;
        cyc   = 0;
        fired = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            next_cycle();
            cyc++;
            if (!bus.in_valid || fired) begin
                if ($urandom_range(0, 3) != 0) begin
                    case ($urandom_range(0, 7))
                        0:       drive(1'b1, 16'hFFFF, W'($urandom), 1'($urandom));
                        1:       drive(1'b1, 16'h7FFF, 16'h7FFF >> $urandom_range(0, 15), 1'($urandom));
                        default: drive(1'b1, W'($urandom), W'($urandom), 1'($urandom));
                    endcase
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            fired = bus.in_valid && bus.in_ready;
            if (fired) sent++;
        end
        if (sent < 10000) chk("rand_budget", 32'(sent), 32'd10000);
        next_cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) next_cycle();
        @(negedge clk);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Two-stage pipelined W-bit carry-lookahead adder built from 4-bit groups.
- Stage 1 computes the per-bit generate/propagate terms and the per-group GG/PP terms.
- Stage 2 runs the second-level lookahead over the group GG/PP, then forms the in-group carries, sum, carry-out and signed overflow.
- Sits downstream of the 4-bit group P/G logic and upstream of the ALU result register. A valid/ready handshake on both sides carries backpressure.

Parameters:
- NGRP, 4, number of 4-bit groups; legal values 2..4; W = 4*NGRP.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset; clears all valid flags and output registers.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry into bit 0.
- out_valid  out  1  result held in output register.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  W  a+b+cin, modulo 2^W.
- cout  out  1  carry out of bit W-1.
- ovf  out  1  signed overflow, equal to c[W] xor c[W-1].

Behaviour:
- Accept/emit rules:
  - Input accepted when in_valid & in_ready (in_fire).
  - Output consumed when out_valid & out_ready (out_fire).
- Stage 1 register (valid v1) holds:
  - per-bit g=a&b and p=a^b (W bits each);
  - per-group GG_k = g3|p3g2|p3p2g1|p3p2p1g0;
  - per-group PP_k = p3&p2&p1&p0;
  - cin.
- Stage 2 / output register (valid v2 = out_valid):
  - Group carries, flattened lookahead, not rippled:
    - C0 = cin;
    - C(k+1) = GG_k | PP_k&GG_(k-1) | ... | PP_k..PP_0&cin.
  - In-group carries: c(i+1) = g_i | p_i&c_i, seeded by C_k.
  - sum_i = p_i ^ c_i; cout = C_NGRP; ovf = c[W] ^ c[W-1].
- Load enables:
  - s2_en = !v2 | out_ready; stage 2 loads the stage-1 contents when s2_en.
  - v2 next = v1 when s2_en; otherwise v2 holds.
  - in_ready = !v1 | s2_en. This is combinational from out_ready; document it for integrators.
  - Stage 1 loads a/b/cin terms on in_fire. v1 next = in_fire when (!v1 | s2_en); otherwise v1 holds.
- Latency and throughput:
  - out_valid asserts on the 2nd rising edge after in_fire when out_ready stays high.
  - Throughput is 1 result per cycle with no bubbles.
- Backpressure:
  - With out_ready low, both stages fill and then in_ready drops.
  - Results held in a stalled stage must not change. sum/cout/ovf are stable while out_valid & !out_ready.
- Ordering: results leave in acceptance order; no drop, no duplication.
- Reset:
  - Asynchronous; v1=v2=0, sum=0, cout=0, ovf=0, stage-1 data=0.
  - In-flight beats are discarded.
  - in_ready is 1 during and after reset because v1=0.
- Simultaneous events:
  - in_fire and out_fire in the same cycle with both stages full: shift both stages, occupancy unchanged.
  - out_ready high with v2=0: no effect.
- Unsupported NGRP: elaboration error via a generate-time check.

Decomposition:
- Package cla_pkg:
  - GRP_W=4;
  - function group_gp(g[3:0], p[3:0]) returning {GG,PP};
  - lookahead carry function over NGRP groups.
- One sub-module: cla_group4.
  - Combinational.
  - Takes a[3:0], b[3:0]; returns g[3:0], p[3:0], GG, PP.
  - Instantiated NGRP times in stage 1.
- Stage-2 carry and sum logic stays inline in cla_pipe_adder.

Test Plan:
- NGRP=4, out_ready=1, beat a=0xFFFF, b=0x0001, cin=0 -> 2 cycles later sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
- a=0x8000, b=0x8000, cin=1 -> sum=0x0001, cout=1, ovf=1.
- a=0xFFFF, b=0x0000, cin=1 (full-width propagate chain) -> sum=0x0000, cout=1.
- Back-to-back: 8 consecutive beats (i, 3*i, cin=i[0]) with out_ready=1 -> out_valid high on 8 consecutive cycles starting at cycle 2, results in order, in_ready never low.
- Backpressure: out_ready=0 while feeding 3 beats:
  - 2 accepted, then in_ready=0;
  - sum held stable;
  - raise out_ready -> beats 1, 2, 3 emerge in order.
- Reset mid-operation: assert rst with v1=v2=1 -> out_valid=0 and sum=0 immediately (asynchronous); after release, in_ready=1 and no stale result ever appears.
- Random: 10k beats with random out_ready, compared against a+b+cin with reference signed overflow.
